decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 49 ++++
 rtl/decode_ctrl.sv | 89 ++++++++
 rtl/decode_regfile.sv | 35 +++
 rtl/decode_stage.sv | 194 +++++++++++++++++++
 tb/tb_decode_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct encodings, ALU control enum and the
// control bundle that travels from ID to EX.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU_ADD must stay the zero encoding so an all-zero bundle is a clean bubble.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_ctrl_t;

  typedef struct packed {
    logic      regwrite;
    logic      memtoreg;
    logic      memwrite;
    logic      branch;
    logic      bne;
    logic      alusrc;
    logic      regdst;
    logic      jump;
    logic      link;
    logic      jr;
    logic      zeroext;
    alu_ctrl_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational main decoder: opcode/funct to control bundle and operand usage.
// j/jal are only recognised when DECODE_JAL_EN is defined.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       uses_rs,
  output logic       uses_rt,
  output logic       legal
);

  always_comb begin
    ctrl    = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    legal   = 1'b1;
    case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        case (funct)
          FN_ADD: ctrl.alu_op = ALU_ADD;
          FN_SUB: ctrl.alu_op = ALU_SUB;
          FN_AND: ctrl.alu_op = ALU_AND;
          FN_OR:  ctrl.alu_op = ALU_OR;
          FN_XOR: ctrl.alu_op = ALU_XOR;
          FN_SLT: ctrl.alu_op = ALU_SLT;
          FN_JR: begin
            ctrl.regwrite = 1'b0;
            ctrl.regdst   = 1'b0;
            ctrl.jr       = 1'b1;
            uses_rt       = 1'b0;
          end
          default: begin
            ctrl    = '0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
            legal   = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        uses_rs       = 1'b1;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        uses_rs       = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.zeroext  = 1'b1;
        ctrl.alu_op   = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        uses_rs       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.bne    = (op == OP_BNE);
        ctrl.alu_op = ALU_SUB;
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
      end
`ifdef DECODE_JAL_EN
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.link     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_regfile.sv
// Register file with two read ports, write-first bypass and a hardwired-zero r0.
module decode_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [$clog2(NREG)-1:0] raddr_a,
  input  logic [$clog2(NREG)-1:0] raddr_b,
  output logic [XLEN-1:0]         rdata_a,
  output logic [XLEN-1:0]         rdata_b
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  assign rdata_a = (raddr_a == '0) ? '0 :
                   (we && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 :
                   (we && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: IF/ID register, hazard/stall logic, MEM forwarding,
// branch/jr redirect and the ID/EX register. DECODE_JAL_EN enables j/jal.
module decode_stage
  import decode_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NREG      = 32,
  parameter logic [XLEN-1:0] RESET_PC4 = '0
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    valid_f,
  input  logic [31:0]             instr_f,
  input  logic [XLEN-1:0]         pcplus4_f,
  input  logic                    flush_d,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  input  logic [XLEN-1:0]         alu_out_m,
  output logic                    stall_d,
  output logic                    pcsrc_d,
  output logic [XLEN-1:0]         pcbranch_d,
  output logic                    jumpreg_d,
  output logic [XLEN-1:0]         jrtarget_d,
  output logic                    valid_e,
  output ctrl_t                   ctrl_e,
  output logic [XLEN-1:0]         srca_e,
  output logic [XLEN-1:0]         srcb_e,
  output logic [XLEN-1:0]         imm_e,
  output logic [$clog2(NREG)-1:0] rs_e,
  output logic [$clog2(NREG)-1:0] rt_e,
  output logic [$clog2(NREG)-1:0] rd_e
);

  localparam int IDXW = $clog2(NREG);

  typedef struct packed {
    logic            regwrite;
    logic            memtoreg;
    logic [IDXW-1:0] dst;
  } shadow_t;

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  shadow_t         ex_q, ex_d, mem_q, mem_d;
  logic            valid_e_q, valid_e_d;
  ctrl_t           ctrl_e_q, ctrl_e_d;
  logic [XLEN-1:0] srca_e_q, srca_e_d, srcb_e_q, srcb_e_d, imm_e_q, imm_e_d;
  logic [IDXW-1:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d, rd_e_q, rd_e_d;

  ctrl_t           ctrl;
  logic            uses_rs, uses_rt, legal;
  logic [IDXW-1:0] rs, rt, dst;
  logic [XLEN-1:0] rf_a, rf_b, opa, opb, simm, zimm, br_target, jmp_target;
  logic            fwd_a, fwd_b, ex_hit_rs, ex_hit_rt, mem_ld_rs, mem_ld_rt;
  logic            load_use, branch_hz, take, issue;
  logic            unused_shamt;

  assign rs           = instr_q[21 +: IDXW];
  assign rt           = instr_q[16 +: IDXW];
  assign unused_shamt = ^instr_q[10:6];

  decode_ctrl u_ctrl (
    .op      (instr_q[31:26]),
    .funct   (instr_q[5:0]),
    .ctrl    (ctrl),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt),
    .legal   (legal)
  );

  decode_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // Only non-load MEM results can be forwarded; loads and EX producers stall instead.
  always_comb begin
    dst        = ctrl.link ? IDXW'(NREG - 1) : (ctrl.regdst ? instr_q[11 +: IDXW] : rt);
    simm       = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
    zimm       = {{(XLEN-16){1'b0}}, instr_q[15:0]};
    br_target  = pc4_q + (simm << 2);
    jmp_target = {pc4_q[XLEN-1:28], instr_q[25:0], 2'b00};
    fwd_a      = mem_q.regwrite && !mem_q.memtoreg && (mem_q.dst != '0) && (mem_q.dst == rs);
    fwd_b      = mem_q.regwrite && !mem_q.memtoreg && (mem_q.dst != '0) && (mem_q.dst == rt);
    opa        = fwd_a ? alu_out_m : rf_a;
    opb        = fwd_b ? alu_out_m : rf_b;
    ex_hit_rs  = ex_q.regwrite && (ex_q.dst != '0) && (ex_q.dst == rs);
    ex_hit_rt  = ex_q.regwrite && (ex_q.dst != '0) && (ex_q.dst == rt);
    mem_ld_rs  = mem_q.regwrite && mem_q.memtoreg && (mem_q.dst != '0) && (mem_q.dst == rs);
    mem_ld_rt  = mem_q.regwrite && mem_q.memtoreg && (mem_q.dst != '0) && (mem_q.dst == rt);
    load_use   = ex_q.memtoreg && ((uses_rs && ex_hit_rs) || (uses_rt && ex_hit_rt));
    branch_hz  = (ctrl.branch && (ex_hit_rs || ex_hit_rt || mem_ld_rs || mem_ld_rt)) ||
                 (ctrl.jr && (ex_hit_rs || mem_ld_rs));
  end

  assign stall_d    = valid_q && (load_use || branch_hz);
  assign take       = valid_q && !stall_d && !flush_d;
  assign issue      = take && legal;
  assign pcsrc_d    = take && ((ctrl.branch && (ctrl.bne ? (opa != opb) : (opa == opb))) ||
                               ctrl.jump);
  assign pcbranch_d = ctrl.jump ? jmp_target : br_target;
  assign jumpreg_d  = take && ctrl.jr;
  assign jrtarget_d = opa;

  // A redirect or external flush discards whatever fetch delivers, even while stalled.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (!stall_d) begin
      valid_d = valid_f;
      instr_d = instr_f;
      pc4_d   = pcplus4_f;
    end
    if (flush_d || pcsrc_d || jumpreg_d) valid_d = 1'b0;
  end

  always_comb begin
    valid_e_d = 1'b0;
    ctrl_e_d  = '0;
    srca_e_d  = '0;
    srcb_e_d  = '0;
    imm_e_d   = '0;
    rs_e_d    = '0;
    rt_e_d    = '0;
    rd_e_d    = '0;
    ex_d      = '0;
    if (issue) begin
      valid_e_d   = 1'b1;
      ctrl_e_d    = ctrl;
      srca_e_d    = ctrl.link ? pc4_q : opa;
      srcb_e_d    = opb;
      imm_e_d     = ctrl.zeroext ? zimm : simm;
      rs_e_d      = rs;
      rt_e_d      = rt;
      rd_e_d      = dst;
      ex_d.regwrite = ctrl.regwrite;
      ex_d.memtoreg = ctrl.memtoreg;
      ex_d.dst      = dst;
    end
    mem_d = ex_q;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc4_q     <= RESET_PC4;
      ex_q      <= '0;
      mem_q     <= '0;
      valid_e_q <= 1'b0;
      ctrl_e_q  <= '0;
      srca_e_q  <= '0;
      srcb_e_q  <= '0;
      imm_e_q   <= '0;
      rs_e_q    <= '0;
      rt_e_q    <= '0;
      rd_e_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      valid_e_q <= valid_e_d;
      ctrl_e_q  <= ctrl_e_d;
      srca_e_q  <= srca_e_d;
      srcb_e_q  <= srcb_e_d;
      imm_e_q   <= imm_e_d;
      rs_e_q    <= rs_e_d;
      rt_e_q    <= rt_e_d;
      rd_e_q    <= rd_e_d;
    end
  end

  assign valid_e = valid_e_q;
  assign ctrl_e  = ctrl_e_q;
  assign srca_e  = srca_e_q;
  assign srcb_e  = srcb_e_q;
  assign imm_e   = imm_e_q;
  assign rs_e    = rs_e_q;
  assign rt_e    = rt_e_q;
  assign rd_e    = rd_e_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hazards, forwarding, redirects, flush and reset.
// Jump checks follow DECODE_JAL_EN.
module tb_decode_stage;
  import decode_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        valid_f = 1'b0;
  logic [31:0] instr_f = '0;
  logic [31:0] pcplus4_f = '0;
  logic        flush_d = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] alu_out_m = '0;
  logic        stall_d, pcsrc_d, jumpreg_d, valid_e;
  logic [31:0] pcbranch_d, jrtarget_d, srca_e, srcb_e, imm_e;
  ctrl_t       ctrl_e;
  logic [4:0]  rs_e, rt_e, rd_e;

  int vectors = 0;
  int miscompares = 0;

  decode_stage dut (
    .CLK(CLK), .RSTn(RSTn), .valid_f(valid_f), .instr_f(instr_f), .pcplus4_f(pcplus4_f),
    .flush_d(flush_d), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .alu_out_m(alu_out_m), .stall_d(stall_d), .pcsrc_d(pcsrc_d), .pcbranch_d(pcbranch_d),
    .jumpreg_d(jumpreg_d), .jrtarget_d(jrtarget_d), .valid_e(valid_e), .ctrl_e(ctrl_e),
    .srca_e(srca_e), .srcb_e(srcb_e), .imm_e(imm_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    valid_f = 1'b0; instr_f = '0; flush_d = 1'b0; wb_we = 1'b0; alu_out_m = '0;
    repeat (n) tick();
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc4);
    valid_f = 1'b1; instr_f = ins; pcplus4_f = pc4;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    idle(2);
    RSTn = 1'b1;
    #1;
    vectors++; if (valid_e !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid_e: got %0b want 0", valid_e); end
    vectors++; if (stall_d !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stall: got %0b want 0", stall_d); end
    vectors++; if (pcsrc_d !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pcsrc: got %0b want 0", pcsrc_d); end
    vectors++; if (ctrl_e !== ctrl_t'('0)) begin miscompares++; $display("[TB] FAIL rst_ctrl: got %h want 0", ctrl_e); end
    vectors++; if (pcbranch_d !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_pcbranch: got %h want 0", pcbranch_d); end
  endtask

  task automatic preload_regs();
    wb_we = 1'b1;
    wb_addr = 5'd1; wb_data = 32'h100; tick();
    wb_addr = 5'd4; wb_data = 32'h5;   tick();
    wb_addr = 5'd6; wb_data = 32'h7;   tick();
    wb_we = 1'b0;
  endtask

  task automatic test_regfile_bypass();
    idle(3);
    fetch(enc_r(9, 0, 10, FN_ADD), 32'h10); tick();
    valid_f = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hABCD; tick();
    wb_we = 1'b0;
    vectors++; if (srca_e !== 32'hABCD) begin miscompares++; $display("[TB] FAIL wb_bypass: got %h want 0000abcd", srca_e); end
    vectors++; if (rd_e !== 5'd10) begin miscompares++; $display("[TB] FAIL wb_rd: got %0d want 10", rd_e); end
    fetch(enc_r(0, 9, 11, FN_ADD), 32'h14); tick();
    valid_f = 1'b0; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h55; tick();
    wb_we = 1'b0;
    vectors++; if (srca_e !== 32'h0) begin miscompares++; $display("[TB] FAIL r0_bypass: got %h want 0", srca_e); end
    vectors++; if (srcb_e !== 32'hABCD) begin miscompares++; $display("[TB] FAIL r9_read: got %h want 0000abcd", srcb_e); end
    fetch(enc_r(0, 0, 12, FN_ADD), 32'h18); tick();
    valid_f = 1'b0; tick();
    vectors++; if (srca_e !== 32'h0) begin miscompares++; $display("[TB] FAIL r0_read: got %h want 0", srca_e); end
  endtask

  task automatic test_load_use();
    idle(3);
    fetch(enc_i(OP_LW, 1, 2, 16'h0), 32'h20); tick();
    fetch(enc_r(2, 4, 3, FN_ADD), 32'h24); #1;
    vectors++; if (stall_d !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_lw_nostall: got %0b want 0", stall_d); end
    tick();
    valid_f = 1'b0; #1;
    vectors++; if (stall_d !== 1'b1) begin miscompares++; $display("[TB] FAIL lu_stall: got %0b want 1", stall_d); end
    vectors++; if (srca_e !== 32'h100) begin miscompares++; $display("[TB] FAIL lu_lw_base: got %h want 00000100", srca_e); end
    vectors++; if (ctrl_e.memtoreg !== 1'b1) begin miscompares++; $display("[TB] FAIL lu_lw_ctrl: got %0b want 1", ctrl_e.memtoreg); end
    tick();
    vectors++; if (valid_e !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_bubble: got %0b want 0", valid_e); end
    vectors++; if (stall_d !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_release: got %0b want 0", stall_d); end
    tick();
    vectors++; if (valid_e !== 1'b1) begin miscompares++; $display("[TB] FAIL lu_issue: got %0b want 1", valid_e); end
    vectors++; if (rd_e !== 5'd3) begin miscompares++; $display("[TB] FAIL lu_rd: got %0d want 3", rd_e); end
    vectors++; if (srcb_e !== 32'h5) begin miscompares++; $display("[TB] FAIL lu_srcb: got %h want 5", srcb_e); end
  endtask

  task automatic test_branch_hazard();
    idle(3);
    fetch(enc_i(OP_ADDI, 0, 5, 16'd7), 32'h1FC); tick();
    fetch(enc_i(OP_BEQ, 5, 6, 16'd4), 32'h200); tick();
    fetch(enc_r(1, 1, 13, FN_ADD), 32'h204); #1;
    vectors++; if (stall_d !== 1'b1) begin miscompares++; $display("[TB] FAIL br_stall: got %0b want 1", stall_d); end
    vectors++; if (pcsrc_d !== 1'b0) begin miscompares++; $display("[TB] FAIL br_pcsrc_stalled: got %0b want 0", pcsrc_d); end
    tick();
    alu_out_m = 32'h7; #1;
    vectors++; if (stall_d !== 1'b0) begin miscompares++; $display("[TB] FAIL br_release: got %0b want 0", stall_d); end
    vectors++; if (pcsrc_d !== 1'b1) begin miscompares++; $display("[TB] FAIL br_taken: got %0b want 1", pcsrc_d); end
    vectors++; if (pcbranch_d !== 32'h210) begin miscompares++; $display("[TB] FAIL br_target: got %h want 00000210", pcbranch_d); end
    vectors++; if (valid_e !== 1'b0) begin miscompares++; $display("[TB] FAIL br_bubble: got %0b want 0", valid_e); end
    tick();
    alu_out_m = '0; valid_f = 1'b0; #1;
    vectors++; if (ctrl_e.branch !== 1'b1) begin miscompares++; $display("[TB] FAIL br_issue: got %0b want 1", ctrl_e.branch); end
    tick();
    vectors++; if (valid_e !== 1'b0) begin miscompares++; $display("[TB] FAIL br_slot_flushed: got %0b want 0", valid_e); end
  endtask

  task automatic test_branch_operands();
    idle(3);
    fetch(enc_i(OP_BEQ, 6, 4, 16'h0004), 32'h300); tick();
    valid_f = 1'b0; #1;
    vectors++; if (pcsrc_d !== 1'b0) begin miscompares++; $display("[TB] FAIL beq_not_taken: got %0b want 0", pcsrc_d); end
    tick();
    fetch(enc_i(OP_BNE, 6, 4, 16'hFFFE), 32'h300); tick();
    valid_f = 1'b0; #1;
    vectors++; if (pcsrc_d !== 1'b1) begin miscompares++; $display("[TB] FAIL bne_taken: got %0b want 1", pcsrc_d); end
    vectors++; if (pcbranch_d !== 32'h2F8) begin miscompares++; $display("[TB] FAIL bne_back_target: got %h want 000002f8", pcbranch_d); end
    tick();
    fetch(enc_i(OP_ANDI, 1, 7, 16'h8000), 32'h400); tick();
    fetch(enc_i(OP_ADDI, 1, 7, 16'h8000), 32'h404); tick();
    vectors++; if (imm_e !== 32'h0000_8000) begin miscompares++; $display("[TB] FAIL andi_zext: got %h want 00008000", imm_e); end
    vectors++; if (ctrl_e.alu_op !== ALU_AND) begin miscompares++; $display("[TB] FAIL andi_alu: got %0d want %0d", ctrl_e.alu_op, ALU_AND); end
    valid_f = 1'b0; tick();
    vectors++; if (imm_e !== 32'hFFFF_8000) begin miscompares++; $display("[TB] FAIL addi_sext: got %h want ffff8000", imm_e); end
  endtask

  task automatic test_jr_forward();
    idle(3);
    fetch(enc_r(1, 4, 8, FN_ADD), 32'h500); tick();
    fetch(enc_r(1, 1, 14, FN_ADD), 32'h504); tick();
    fetch(enc_r(8, 0, 0, FN_JR), 32'h508); tick();
    valid_f = 1'b0; alu_out_m = 32'h10; #1;
    vectors++; if (stall_d !== 1'b0) begin miscompares++; $display("[TB] FAIL jr_mem_nostall: got %0b want 0", stall_d); end
    vectors++; if (jumpreg_d !== 1'b1) begin miscompares++; $display("[TB] FAIL jr_jumpreg: got %0b want 1", jumpreg_d); end
    vectors++; if (jrtarget_d !== 32'h10) begin miscompares++; $display("[TB] FAIL jr_fwd_target: got %h want 00000010", jrtarget_d); end
    idle(3);
    fetch(enc_r(1, 4, 8, FN_ADD), 32'h600); tick();
    fetch(enc_r(8, 0, 0, FN_JR), 32'h604); tick();
    valid_f = 1'b0; #1;
    vectors++; if (stall_d !== 1'b1) begin miscompares++; $display("[TB] FAIL jr_ex_stall: got %0b want 1", stall_d); end
    vectors++; if (jumpreg_d !== 1'b0) begin miscompares++; $display("[TB] FAIL jr_stall_gate: got %0b want 0", jumpreg_d); end
    tick();
    alu_out_m = 32'h24; #1;
    vectors++; if (jrtarget_d !== 32'h24) begin miscompares++; $display("[TB] FAIL jr_late_target: got %h want 00000024", jrtarget_d); end
    vectors++; if (jumpreg_d !== 1'b1) begin miscompares++; $display("[TB] FAIL jr_late_jump: got %0b want 1", jumpreg_d); end
  endtask

  task automatic test_flush_stall();
    idle(3);
    fetch(enc_i(OP_LW, 1, 2, 16'h0), 32'h700); tick();
    fetch(enc_r(2, 4, 3, FN_ADD), 32'h704); tick();
    valid_f = 1'b0; flush_d = 1'b1; #1;
    vectors++; if (stall_d !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_stall: got %0b want 1", stall_d); end
    tick();
    flush_d = 1'b0; #1;
    vectors++; if (valid_e !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_valid_e: got %0b want 0", valid_e); end
    vectors++; if (stall_d !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_ifid_cleared: got %0b want 0", stall_d); end
    tick();
    vectors++; if (valid_e !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_no_issue: got %0b want 0", valid_e); end
  endtask

  task automatic test_jump_opcodes();
    idle(3);
`ifdef DECODE_JAL_EN
    fetch({OP_JAL, 26'h40}, 32'h104); tick();
    valid_f = 1'b0; #1;
    vectors++; if (pcsrc_d !== 1'b1) begin miscompares++; $display("[TB] FAIL jal_redirect: got %0b want 1", pcsrc_d); end
    vectors++; if (pcbranch_d !== 32'h100) begin miscompares++; $display("[TB] FAIL jal_target: got %h want 00000100", pcbranch_d); end
    tick();
    vectors++; if (rd_e !== 5'd31) begin miscompares++; $display("[TB] FAIL jal_dst: got %0d want 31", rd_e); end
    vectors++; if (srca_e !== 32'h104) begin miscompares++; $display("[TB] FAIL jal_link: got %h want 00000104", srca_e); end
    vectors++; if (ctrl_e.regwrite !== 1'b1) begin miscompares++; $display("[TB] FAIL jal_regwrite: got %0b want 1", ctrl_e.regwrite); end
`else
    fetch({OP_JAL, 26'h40}, 32'h104); tick();
    valid_f = 1'b0; #1;
    vectors++; if (pcsrc_d !== 1'b0) begin miscompares++; $display("[TB] FAIL jal_off_redirect: got %0b want 0", pcsrc_d); end
    tick();
    vectors++; if (valid_e !== 1'b0) begin miscompares++; $display("[TB] FAIL jal_off_bubble: got %0b want 0", valid_e); end
    vectors++; if (ctrl_e !== ctrl_t'('0)) begin miscompares++; $display("[TB] FAIL jal_off_ctrl: got %h want 0", ctrl_e); end
    fetch({OP_J, 26'h10}, 32'h108); tick();
    valid_f = 1'b0; #1;
    vectors++; if (pcsrc_d !== 1'b0) begin miscompares++; $display("[TB] FAIL j_off_redirect: got %0b want 0", pcsrc_d); end
`endif
  endtask

  task automatic test_reset_midstream();
    idle(3);
    fetch(enc_i(OP_LW, 1, 2, 16'h4), 32'h800); tick();
    fetch(enc_r(2, 4, 3, FN_ADD), 32'h804); tick();
    valid_f = 1'b0; #1;
    vectors++; if (stall_d !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_pre_stall: got %0b want 1", stall_d); end
    RSTn = 1'b0; tick();
    RSTn = 1'b1; #1;
    vectors++; if (stall_d !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_stall: got %0b want 0", stall_d); end
    vectors++; if (valid_e !== 1'b0) begin miscompares++; $display("[TB] FAIL mr_valid_e: got %0b want 0", valid_e); end
    vectors++; if (srca_e !== 32'h0) begin miscompares++; $display("[TB] FAIL mr_srca: got %h want 0", srca_e); end
    vectors++; if (imm_e !== 32'h0) begin miscompares++; $display("[TB] FAIL mr_imm: got %h want 0", imm_e); end
    vectors++; if (rd_e !== 5'd0) begin miscompares++; $display("[TB] FAIL mr_rd: got %0d want 0", rd_e); end
    vectors++; if (pcbranch_d !== 32'h0) begin miscompares++; $display("[TB] FAIL mr_pcbranch: got %h want 0", pcbranch_d); end
    fetch(enc_r(1, 4, 15, FN_ADD), 32'h900); tick();
    valid_f = 1'b0; tick();
    vectors++; if (valid_e !== 1'b1) begin miscompares++; $display("[TB] FAIL mr_issue: got %0b want 1", valid_e); end
    vectors++; if (srcb_e !== 32'h0) begin miscompares++; $display("[TB] FAIL mr_regs_cleared: got %h want 0", srcb_e); end
  endtask

  initial begin
    test_reset();
    preload_regs();
    test_regfile_bypass();
    test_load_use();
    test_branch_hazard();
    test_branch_operands();
    test_jr_forward();
    test_flush_stall();
    test_jump_opcodes();
    test_reset_midstream();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
